uart_rx_ctrl: RTL and testbench

Frame-sequencing controller for the UART receive path.
- Detects the start bit on the raw rx line and qualifies it at mid-bit.
- Times mid-bit sample strobes for N_BITS data bits, LSB-first, and checks the stop bit.
- Delivers each completed character through a valid/ready holding register, and reports glitch, framing-error and overrun events.
- Sits between the rx pin and the character consumer. It replaces ad-hoc start/stop gating of the bit-clock recovery path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding, line idle level and bit-timing helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam logic RX_IDLE = 1'b1;

   function automatic int bit_cycles(input int clk_rate,
                                     input int baud_rate);
      return clk_rate / baud_rate;
   endfunction

   function automatic int half_cycles(input int clk_max);
      return clk_max / 2;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; evt is high while the count reads zero.
// Ports: clk, rst_n, load, load_val[W-1:0] in; evt out.
module uart_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         evt
);

   logic [W-1:0] cnt;

   // Loading X-1 makes evt fire X cycles after the load cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign evt = (cnt == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer with valid/ready holding register.
// Ports: clk, rst_n, rx, en, data_ready in; data_out, data_valid,
// sample_stb, busy, glitch, frame_err, overrun out.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int N_BITS    = 9,
   parameter int CLK_RATE  = 12000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   input  logic              en,
   output logic [N_BITS-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              sample_stb,
   output logic              busy,
   output logic              glitch,
   output logic              frame_err,
   output logic              overrun
);

   localparam int CLK_MAX = bit_cycles(CLK_RATE, BAUD_RATE);
   localparam int HALF    = half_cycles(CLK_MAX);
   localparam int TW      = $clog2(CLK_MAX);
   localparam int IW      = $clog2(N_BITS);

   localparam logic [IW-1:0] LAST    = IW'(N_BITS - 1);
   localparam logic [TW-1:0] LD_HALF = TW'(HALF - 1);
   localparam logic [TW-1:0] LD_BIT  = TW'(CLK_MAX - 1);

   if (CLK_MAX < 4) begin : g_bad_rate
      $error("uart_rx_ctrl: CLK_MAX must be at least 4");
   end
   if (N_BITS < 2) begin : g_bad_width
      $error("uart_rx_ctrl: N_BITS must be at least 2");
   end

   logic              rx_meta;
   logic              rx_s;
   logic              rx_prev;
   logic              fall;
   state_t            state;
   logic [IW-1:0]     idx;
   logic [N_BITS-1:0] shreg;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= RX_IDLE;
         rx_s    <= RX_IDLE;
         rx_prev <= RX_IDLE;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = (rx_prev == RX_IDLE) && (rx_s != RX_IDLE);

   // Timer reloads: half a bit on start detect, one bit afterwards.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = LD_BIT;
      unique case (state)
         IDLE: begin
            if (en && fall) begin
               tmr_load = 1'b1;
               tmr_val  = LD_HALF;
            end
         end
         START:   tmr_load = en && evt && (rx_s != RX_IDLE);
         DATA:    tmr_load = en && evt;
         default: tmr_load = 1'b0;
      endcase
   end

   uart_bit_timer #(
      .W(TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .evt      (evt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sample_stb <= 1'b0;
         glitch     <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         glitch     <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (en && fall) begin
                  state <= START;
               end
            end
            START: begin
               if (!en) begin
                  state <= IDLE;
               end else if (evt) begin
                  if (rx_s != RX_IDLE) begin
                     state <= DATA;
                     idx   <= '0;
                  end else begin
                     glitch <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            DATA: begin
               if (!en) begin
                  state <= IDLE;
               end else if (evt) begin
                  sample_stb <= 1'b1;
                  shreg      <= {rx_s, shreg[N_BITS-1:1]};
                  idx        <= idx + IW'(1);
                  if (idx == LAST) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (!en) begin
                  state <= IDLE;
               end else if (evt) begin
                  sample_stb <= 1'b1;
                  if (rx_s == RX_IDLE) begin
                     state <= IDLE;
                     // A same-cycle handshake frees the slot for the new one.
                     if (!data_valid || data_ready) begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (!en || (rx_s == RX_IDLE)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl.
// 16 clk per bit, 9 data bits, LSB first.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       en;
   logic [8:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       sample_stb;
   logic       busy;
   logic       glitch;
   logic       frame_err;
   logic       overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   int n_stb;
   int n_glitch;
   int n_ferr;
   int n_ovr;
   int n_vcyc;
   int n_deliv;
   int rise_cyc;
   logic valid_q = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_w;

   int c0;

   uart_rx_ctrl #(
      .N_BITS    (9),
      .CLK_RATE  (16),
      .BAUD_RATE (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .en         (en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sample_stb (sample_stb),
      .busy       (busy),
      .glitch     (glitch),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_counts();
      n_stb    = 0;
      n_glitch = 0;
      n_ferr   = 0;
      n_ovr    = 0;
      n_vcyc   = 0;
      n_deliv  = 0;
      rise_cyc = -1;
   endtask

   task automatic send_frame(input logic [8:0] d,
                             input logic stop_lvl,
                             input int stop_len);
      rx = 1'b0;
      tick(16);
      for (int k = 0; k < 9; k++) begin
         rx = d[k];
         tick(16);
      end
      rx = stop_lvl;
      tick(stop_len);
      rx = 1'b1;
   endtask

   // Output monitor, sampled 1 time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (sample_stb) n_stb++;
         if (glitch) n_glitch++;
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
         if (data_valid) n_vcyc++;
         if (data_valid && !valid_q) rise_cyc = cyc;
         if (data_valid && data_ready) begin
            n_deliv++;
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL sb_underflow: observed 0x%0h expected none",
                      data_out);
            end
            if (exp_q.size() != 0) begin
               exp_w = exp_q.pop_front();
               check("deliver_data", 32'(data_out), exp_w);
            end
         end
      end
      valid_q = data_valid;
   end

   initial begin
      rst_n      = 1'b0;
      rx         = 1'b1;
      en         = 1'b1;
      data_ready = 1'b0;
      clr_counts();
      tick(3);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_flags",
            32'({sample_stb, busy, glitch, frame_err, overrun, data_valid}),
            32'h0);
      rst_n = 1'b1;
      tick(4);

      // clean frame
      clr_counts();
      data_ready = 1'b1;
      exp_q.push_back(32'h0A5);
      c0 = cyc;
      send_frame(9'h0A5, 1'b1, 16);
      tick(4);
      check("clean_rise_cyc", 32'(rise_cyc), 32'(c0 + 2 + 169));
      check("clean_valid_cycles", 32'(n_vcyc), 32'd1);
      check("clean_stb_count", 32'(n_stb), 32'd10);
      check("clean_err_pulses", 32'(n_glitch + n_ferr + n_ovr), 32'd0);
      check("clean_deliveries", 32'(n_deliv), 32'd1);

      // glitch
      clr_counts();
      c0 = cyc;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(6);
      check("glitch_busy_at_e8", 32'(busy), 32'd1);
      tick(1);
      check("glitch_busy_after", 32'(busy), 32'd0);
      tick(20);
      check("glitch_pulses", 32'(n_glitch), 32'd1);
      check("glitch_stb", 32'(n_stb), 32'd0);

      // framing error then recovery
      clr_counts();
      c0 = cyc;
      send_frame(9'h1FF, 1'b0, 20);
      check("ferr_break_busy", 32'(busy), 32'd1);
      check("ferr_pulses", 32'(n_ferr), 32'd1);
      check("ferr_no_valid", 32'(n_vcyc), 32'd0);
      tick(5);
      check("ferr_idle", 32'(busy), 32'd0);
      exp_q.push_back(32'h003);
      send_frame(9'h003, 1'b1, 16);
      tick(4);
      check("ferr_next_deliv", 32'(n_deliv), 32'd1);

      // overrun, consumer stalled
      clr_counts();
      data_ready = 1'b0;
      exp_q.push_back(32'h011);
      send_frame(9'h011, 1'b1, 16);
      send_frame(9'h022, 1'b1, 16);
      tick(4);
      check("ovr_pulses", 32'(n_ovr), 32'd1);
      check("ovr_data_kept", 32'(data_out), 32'h011);
      check("ovr_valid", 32'(data_valid), 32'd1);
      data_ready = 1'b1;
      tick(3);
      data_ready = 1'b0;
      check("ovr_drain", 32'(n_deliv), 32'd1);

      // ready exactly in the second stop-event cycle
      clr_counts();
      exp_q.push_back(32'h011);
      exp_q.push_back(32'h022);
      send_frame(9'h011, 1'b1, 16);
      fork
         send_frame(9'h022, 1'b1, 16);
         begin
            tick(170);
            data_ready = 1'b1;
            tick(1);
            data_ready = 1'b0;
         end
      join
      tick(4);
      check("swap_no_ovr", 32'(n_ovr), 32'd0);
      check("swap_data", 32'(data_out), 32'h022);
      data_ready = 1'b1;
      tick(3);
      check("swap_deliveries", 32'(n_deliv), 32'd2);

      // abort with en low mid-DATA
      clr_counts();
      rx = 1'b0;
      tick(60);
      en = 1'b0;
      tick(1);
      check("abort_busy", 32'(busy), 32'd0);
      rx = 1'b1;
      tick(200);
      en = 1'b1;
      tick(2);
      check("abort_no_deliv", 32'(n_deliv + n_vcyc), 32'd0);
      check("abort_no_errs", 32'(n_glitch + n_ferr + n_ovr), 32'd0);

      // asynchronous reset mid-frame
      data_ready = 1'b0;
      send_frame(9'h05A, 1'b1, 16);
      tick(4);
      check("hold_valid", 32'(data_valid), 32'd1);
      check("hold_data", 32'(data_out), 32'h05A);
      rx = 1'b0;
      tick(50);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_data_out", 32'(data_out), 32'h0);
      check("arst_flags",
            32'({sample_stb, busy, glitch, frame_err, overrun, data_valid}),
            32'h0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
